writeback_arbiter: RTL and testbench

Merges the ALU and load-unit writeback streams into the register file's single write port. Each source has a valid/ready handshake. Up to two results are accepted per cycle into a DEPTH-entry FIFO, and one entry is drained per cycle. The block drives the register file's write_enable, inp_write_address0 and inp_write_data. It also publishes a pending-register mask for hazard detection and, optionally, a forwarding lookup.

---
 rtl/writeback_arbiter.sv | 103 ++++++++++
 tb/tb_writeback_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and load writebacks into one register-file write port via a DEPTH-entry FIFO.
// Define WB_FORWARD_EN to build the forwarding lookup; otherwise lookup outputs are tied to 0.
module writeback_arbiter #(
  parameter int W         = 16,
  parameter int ADDR_BITS = 4,
  parameter int NUM_REGS  = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset_asynchronous_n,
  input  logic                 inp_alu_valid,
  input  logic [ADDR_BITS-1:0] inp_alu_address,
  input  logic [W-1:0]         inp_alu_data,
  output logic                 out_alu_ready,
  input  logic                 inp_mem_valid,
  input  logic [ADDR_BITS-1:0] inp_mem_address,
  input  logic [W-1:0]         inp_mem_data,
  output logic                 out_mem_ready,
  output logic                 out_write_enable,
  output logic [ADDR_BITS-1:0] out_write_address,
  output logic [W-1:0]         out_write_data,
  output logic [NUM_REGS-1:0]  out_pending,
  input  logic [ADDR_BITS-1:0] inp_lookup_address,
  output logic                 out_lookup_hit,
  output logic [W-1:0]         out_lookup_data
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {ALU, MEM} src_t;
  src_t first_q;
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0] count_q, free;
  logic [ADDR_BITS-1:0] addr_q [DEPTH];
  logic [W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] ent_v;
  logic alu_push, mem_push, pop, alu_at_tail;
  logic [1:0] n_push;
  assign free = (PW+1)'(DEPTH) - count_q;
  // With one free slot the tie goes to `first`; a lone requester always wins.
  assign out_alu_ready = reset_asynchronous_n && (free >= 2 || (free == 1 && (first_q == ALU || !inp_mem_valid)));
  assign out_mem_ready = reset_asynchronous_n && (free >= 2 || (free == 1 && (first_q == MEM || !inp_alu_valid)));
  assign alu_push = inp_alu_valid && out_alu_ready;
  assign mem_push = inp_mem_valid && out_mem_ready;
  assign n_push = {1'b0, alu_push} + {1'b0, mem_push};
  assign pop = count_q != 0;
  assign alu_at_tail = alu_push && (!mem_push || first_q == ALU);
  always_ff @(posedge clk) begin
    if (n_push != 0) begin
      addr_q[tail_q] <= alu_at_tail ? inp_alu_address : inp_mem_address;
      data_q[tail_q] <= alu_at_tail ? inp_alu_data : inp_mem_data;
    end
    if (n_push == 2) begin
      addr_q[tail_q + PW'(1)] <= alu_at_tail ? inp_mem_address : inp_alu_address;
      data_q[tail_q + PW'(1)] <= alu_at_tail ? inp_mem_data : inp_alu_data;
    end
  end
  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      first_q <= ALU;
      out_write_enable <= 1'b0;
      out_write_address <= '0;
      out_write_data <= '0;
    end else begin
      head_q <= head_q + PW'(pop);
      tail_q <= tail_q + PW'(n_push);
      count_q <= count_q + (PW+1)'(n_push) - (PW+1)'(pop);
      if (inp_alu_valid && inp_mem_valid) first_q <= first_q == ALU ? MEM : ALU;
      out_write_enable <= pop;
      if (pop) begin
        out_write_address <= addr_q[head_q];
        out_write_data <= data_q[head_q];
      end
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_v[i] = {1'b0, PW'(i) - head_q} < count_q;
  end
  always_comb begin
    out_pending = '0;
    if (out_write_enable) out_pending[out_write_address] = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (ent_v[i]) out_pending[addr_q[i]] = 1'b1;
  end
`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    out_lookup_hit = out_write_enable && out_write_address == inp_lookup_address;
    out_lookup_data = out_lookup_hit ? out_write_data : '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_v[head_q + PW'(k)] && addr_q[head_q + PW'(k)] == inp_lookup_address) begin
        out_lookup_hit = 1'b1;
        out_lookup_data = data_q[head_q + PW'(k)];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^inp_lookup_address;
  assign out_lookup_hit = 1'b0;
  assign out_lookup_data = '0;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed checks of writeback_arbiter with default parameters.
module tb_writeback_arbiter;
  logic clk = 0, rst_n = 0;
  logic alu_valid = 0, mem_valid = 0, alu_ready, mem_ready;
  logic [3:0] alu_address = 0, mem_address = 0, write_address, lookup_address = 0;
  logic [15:0] alu_data = 0, mem_data = 0, write_data, lookup_data, pending;
  logic write_enable, lookup_hit;
  int checks = 0, errors = 0;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1;
`else
  localparam bit FWD = 0;
`endif
  always #5 clk = ~clk;
  writeback_arbiter dut (
    .clk(clk), .reset_asynchronous_n(rst_n),
    .inp_alu_valid(alu_valid), .inp_alu_address(alu_address), .inp_alu_data(alu_data), .out_alu_ready(alu_ready),
    .inp_mem_valid(mem_valid), .inp_mem_address(mem_address), .inp_mem_data(mem_data), .out_mem_ready(mem_ready),
    .out_write_enable(write_enable), .out_write_address(write_address), .out_write_data(write_data),
    .out_pending(pending), .inp_lookup_address(lookup_address),
    .out_lookup_hit(lookup_hit), .out_lookup_data(lookup_data)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [15:0] md);
    alu_valid = av; alu_address = aa; alu_data = ad;
    mem_valid = mv; mem_address = ma; mem_data = md;
  endtask
  task automatic wr(input string tag, input logic we, input logic [3:0] a, input logic [15:0] d);
    check({tag, "_we"}, write_enable, we);
    check({tag, "_addr"}, write_address, a);
    check({tag, "_data"}, write_data, d);
  endtask
  logic [19:0] exp_q[$];
  logic [19:0] e;
  int cnt_m, na, nm;
  bit first_mem, ea, em, pop_m;
  initial begin
    #1;
    check("rst_alu_rdy", alu_ready, 0);
    check("rst_mem_rdy", mem_ready, 0);
    step; step;
    rst_n = 1;
    #1;
    wr("idle", 0, 0, 0);
    check("idle_pend", pending, 0);
    check("idle_alu_rdy", alu_ready, 1);
    check("idle_mem_rdy", mem_ready, 1);
    rst_n = 0;
    step;
    rst_n = 1;
    #1;
    wr("idle2", 0, 0, 0);
    check("idle2_pend", pending, 0);
    check("idle2_alu_rdy", alu_ready, 1);
    check("idle2_mem_rdy", mem_ready, 1);
    // single ALU write latency
    drive(1, 3, 16'h9876, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 0, 0);
    check("lat_e1_we", write_enable, 0);
    check("lat_e1_pend", pending, 16'h0008);
    step;
    wr("lat_e2", 1, 3, 16'h9876);
    check("lat_e2_pend", pending, 16'h0008);
    step;
    wr("lat_e3", 0, 3, 16'h9876);
    check("lat_e3_pend", pending, 0);
    // dual acceptance, ALU first
    drive(1, 1, 16'h1111, 1, 2, 16'h2222);
    #1;
    check("dual_alu_rdy", alu_ready, 1);
    check("dual_mem_rdy", mem_ready, 1);
    step;
    drive(0, 0, 0, 0, 0, 0);
    check("dual_e1_pend", pending, 16'h0006);
    step;
    wr("dual_e2", 1, 1, 16'h1111);
    check("dual_e2_pend", pending, 16'h0006);
    step;
    wr("dual_e3", 1, 2, 16'h2222);
    check("dual_e3_pend", pending, 16'h0004);
    step;
    check("dual_e4_we", write_enable, 0);
    // sustained dual load, first is now MEM
    cnt_m = 0; na = 0; nm = 0; first_mem = 1;
    for (int c = 0; c < 10; c++) begin
      drive(1, 4'(na), 16'hA000 + 16'(na), 1, 4'(8 + nm), 16'hB000 + 16'(nm));
      #1;
      ea = (4 - cnt_m) >= 2 || ((4 - cnt_m) == 1 && !first_mem);
      em = (4 - cnt_m) >= 2 || ((4 - cnt_m) == 1 && first_mem);
      check("sus_alu_rdy", alu_ready, ea);
      check("sus_mem_rdy", mem_ready, em);
      if (first_mem) begin
        if (em) exp_q.push_back({mem_address, mem_data});
        if (ea) exp_q.push_back({alu_address, alu_data});
      end else begin
        if (ea) exp_q.push_back({alu_address, alu_data});
        if (em) exp_q.push_back({mem_address, mem_data});
      end
      if (ea) na++;
      if (em) nm++;
      first_mem = !first_mem;
      pop_m = cnt_m > 0;
      cnt_m = cnt_m + int'(ea) + int'(em) - int'(pop_m);
      step;
      check("sus_we", write_enable, pop_m);
      if (pop_m) begin
        e = exp_q.pop_front();
        check("sus_addr", write_address, e[19:16]);
        check("sus_data", write_data, e[15:0]);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 8 && exp_q.size() > 0; g++) begin
      step;
      e = exp_q.pop_front();
      wr("drain", 1, e[19:16], e[15:0]);
    end
    step;
    check("drain_end_we", write_enable, 0);
    check("drain_end_pend", pending, 0);
    // async reset with entries queued
    drive(1, 10, 16'hC00A, 1, 11, 16'hC00B);
    step;
    drive(1, 12, 16'hC00C, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 0, 0);
    check("q_we", write_enable, 1);
    check("q_pend", pending, 16'h1C00);
    #2;
    rst_n = 0;
    #1;
    check("arst_we", write_enable, 0);
    check("arst_pend", pending, 0);
    check("arst_alu_rdy", alu_ready, 0);
    check("arst_mem_rdy", mem_ready, 0);
    step; step;
    rst_n = 1;
    for (int g = 0; g < 3; g++) begin
      step;
      wr("post_rst", 0, 0, 0);
      check("post_rst_pend", pending, 0);
    end
    // forwarding lookup
    drive(1, 5, 16'hAAAA, 0, 0, 0);
    step;
    drive(1, 5, 16'hBBBB, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 0, 0);
    lookup_address = 5;
    #1;
    check("fwd5_hit", lookup_hit, FWD);
    check("fwd5_data", lookup_data, FWD ? 16'hBBBB : 16'h0);
    lookup_address = 6;
    #1;
    check("fwd6_hit", lookup_hit, 0);
    step;
    lookup_address = 5;
    #1;
    check("fwd_out_hit", lookup_hit, FWD);
    check("fwd_out_data", lookup_data, FWD ? 16'hBBBB : 16'h0);
    wr("fwd_out", 1, 5, 16'hBBBB);
    step;
    check("fwd_end_we", write_enable, 0);
    // repeated address 0 is never merged
    drive(1, 0, 16'h0001, 1, 0, 16'h0002);
    step;
    drive(0, 0, 0, 0, 0, 0);
    step;
    wr("zero_a", 1, 0, 16'h0001);
    check("zero_pend", pending, 16'h0001);
    step;
    wr("zero_b", 1, 0, 16'h0002);
    step;
    check("zero_end_we", write_enable, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
